uart_rx: RTL and testbench

- UART receiver that sits upstream of the ALU core: it deserialises the host's serial stream into bytes for the operand/opcode path.
- The existing top-level transmit path produces serial output; this block is its input-side counterpart, 8N1, LSB first.
- It samples at mid-bit and presents each byte on a valid/ready handshake.
- It reports framing errors and overruns as single-cycle pulses.

---
 rtl/uart_rx.sv | 182 ++++++++++++++++++
 tb/tb_uart_rx.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- 8N1 serial receiver, LSB first, mid-bit sampling.
//
// Deserialises the host serial stream into bytes for the operand/opcode path.
// Received bytes are held on a valid/ready output. Framing errors and
// overruns are reported as single-cycle pulses.
//
// Handshake: data_o carries a byte whenever valid_o is high. The byte is
// consumed in any cycle where valid_o & ready_i. valid_o then clears in the
// next cycle unless a new byte loads in that same cycle. ready_i is ignored
// while valid_o is low. ready_i reaches no output combinationally.
//
// Ports:
//   clk          in   1  system clock
//   rst          in   1  synchronous active-high reset
//   rx_i         in   1  asynchronous serial line, idle high
//   data_o       out  8  received byte
//   valid_o      out  1  data_o holds an unconsumed byte
//   ready_i      in   1  consumer accepts when valid_o & ready_i
//   busy_o       out  1  frame in progress (state != IDLE)
//   frame_err_o  out  1  one-cycle pulse: stop bit sampled low
//   overrun_o    out  1  one-cycle pulse: unaccepted byte was overwritten
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       busy_o,
    output logic       frame_err_o,
    output logic       overrun_o
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CW       = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [2:0]    r_idx;
    logic [2:0]    w_idx_nxt;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift_nxt;
    logic          r_rx_meta;
    logic          r_rx_s;
    logic          w_load;
    logic          w_ferr;
    logic          w_cnt_last;
    logic          w_cnt_half;

    // Two-flop synchroniser; both stages reset to the idle-high line level
    // so a reset never looks like a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx_i;
            r_rx_s    <= r_rx_meta;
        end
    end

    assign w_cnt_last = (r_cnt == CW'(CLKS_PER_BIT - 1));
    assign w_cnt_half = (r_cnt == CW'(HALF_BIT - 1));

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_load      = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_rx_s) begin
                    w_state_nxt = S_START;
                    w_cnt_nxt   = '0;
                end
            end
            S_START: begin
                if (w_cnt_half) begin
                    w_cnt_nxt = '0;
                    w_idx_nxt = '0;
                    // Line back high at mid start bit: treat as a glitch.
                    w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_DATA: begin
                if (w_cnt_last) begin
                    w_cnt_nxt   = '0;
                    // Right shift: first (LSB) bit ends up in bit 0.
                    w_shift_nxt = {r_rx_s, r_shift[7:1]};
                    if (r_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_idx_nxt = r_idx + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_STOP: begin
                if (w_cnt_last) begin
                    w_cnt_nxt = '0;
                    if (r_rx_s) begin
                        w_load      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_ferr      = 1'b1;
                        w_state_nxt = S_WAIT_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_WAIT_IDLE: begin
                // A held-low line (break) must not be taken as a new start.
                if (r_rx_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output register: byte holding stage and error pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_o      <= 8'h00;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            frame_err_o <= w_ferr;
            overrun_o   <= 1'b0;
            if (w_load) begin
                data_o  <= r_shift;
                valid_o <= 1'b1;
                // Accepting the old byte in the load cycle is not an overrun.
                overrun_o <= valid_o & ~ready_i;
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

    assign busy_o = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- bench for uart_rx with CLKS_PER_BIT = 16.
//
// Timing reference: "cycle p" is the cycle in which rx_i is first driven low
// for a start bit. The frame is 160 cycles on the wire (10 bits x 16).
// The receiver presents the byte at p + 3 + 8 + 9*16 = p + 155; the stop bit
// is sampled (and any consumer accept coinciding with a load happens) in
// cycle p + 154; a framing-error pulse appears at p + 155.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic       busy_o;
    logic       frame_err_o;
    logic       overrun_o;

    logic       ready_man;
    logic       ready_rnd;
    logic       rnd_mode;

    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    int         n_ferr = 0;
    int         n_ovr = 0;
    int         exp_ferr = 0;
    int         exp_ovr = 0;
    logic [7:0] exp_q[$];

    assign ready_i = rnd_mode ? ready_rnd : ready_man;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_i        (rx_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .busy_o      (busy_o),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1);
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Move to the drive point (just after posedge) of the next cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_cycle(input int n);
        while (cyc < n) tick();
    endtask

    // Move to the negedge (sample point) of cycle n.
    task automatic wait_neg(input int n);
        do @(negedge clk); while (cyc < n);
        if (cyc != n) check("sample_point_missed", cyc, n);
    endtask

    // Drive one 8N1 frame starting in the current cycle; returns 160 cycles later.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        for (int i = 0; i < 10 * CPB; i++) begin
            if (i < CPB)          rx_i = 1'b0;
            else if (i < 9 * CPB) rx_i = b[(i - CPB) / CPB];
            else                  rx_i = stop;
            tick();
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin : monitor
        logic [7:0] e;
        if (!rst) begin
            if (frame_err_o) n_ferr++;
            if (overrun_o)   n_ovr++;
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", {24'h0, data_o}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("accept_data", {24'h0, data_o}, {24'h0, e});
                end
            end
        end
    end

    // ---------------- random ready driver ----------------
    initial begin
        ready_rnd = 1'b0;
        forever begin
            tick();
            ready_rnd = ($urandom_range(0, 3) == 0);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int p;
        logic [7:0] b;
        logic       good;

        rst       = 1'b1;
        rx_i      = 1'b1;
        ready_man = 1'b0;
        rnd_mode  = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_valid", valid_o, 0);
        check("rst_data", data_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_ferr", frame_err_o, 0);
        check("rst_ovr", overrun_o, 0);
        tick();
        repeat (4) tick();

        // Single byte 0xA5, latency
        ready_man = 1'b1;
        p = cyc;
        exp_q.push_back(8'hA5);
        fork
            send_frame(8'hA5, 1'b1);
            begin
                wait_neg(p + 154);
                check("lat_valid_before", valid_o, 0);
                wait_neg(p + 155);
                check("lat_valid", valid_o, 1);
                check("lat_data", data_o, 8'hA5);
                wait_neg(p + 156);
                check("lat_valid_drop", valid_o, 0);
            end
        join
        repeat (5) tick();

        // Glitch on the start bit
        p = cyc;
        fork
            begin
                rx_i = 1'b0;
                repeat (4) tick();
                rx_i = 1'b1;
            end
            begin
                wait_neg(p + 2);
                check("glitch_busy_pre", busy_o, 0);
                wait_neg(p + 3);
                check("glitch_busy_rise", busy_o, 1);
                wait_neg(p + 10);
                check("glitch_busy_hold", busy_o, 1);
                wait_neg(p + 11);
                check("glitch_busy_fall", busy_o, 0);
            end
        join
        repeat (30) tick();
        check("glitch_no_valid", valid_o, 0);

        // Framing error, break hold, then valid 0x55
        p = cyc;
        exp_ferr++;
        fork
            begin
                send_frame(8'h3C, 1'b0);
                repeat (40) tick();
                rx_i = 1'b1;
            end
            begin
                wait_neg(p + 154);
                check("ferr_pre", frame_err_o, 0);
                wait_neg(p + 155);
                check("ferr_pulse", frame_err_o, 1);
                check("ferr_no_valid", valid_o, 0);
                wait_neg(p + 156);
                check("ferr_post", frame_err_o, 0);
                wait_neg(p + 190);
                check("break_busy", busy_o, 1);
                wait_neg(p + 202);
                check("break_busy_end", busy_o, 1);
                wait_neg(p + 203);
                check("break_idle", busy_o, 0);
            end
        join
        repeat (5) tick();
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        repeat (10) tick();

        // Overrun: 0x11 then 0x22 back-to-back with ready low
        ready_man = 1'b0;
        p = cyc;
        exp_q.push_back(8'h22);
        exp_ovr++;
        fork
            begin
                send_frame(8'h11, 1'b1);
                send_frame(8'h22, 1'b1);
            end
            begin
                wait_neg(p + 155);
                check("ovr_first_valid", valid_o, 1);
                check("ovr_first_data", data_o, 8'h11);
                wait_neg(p + 160 + 154);
                check("ovr_hold_valid", valid_o, 1);
                check("ovr_hold_data", data_o, 8'h11);
                check("ovr_no_pulse_yet", overrun_o, 0);
                wait_neg(p + 160 + 155);
                check("ovr_second_data", data_o, 8'h22);
                check("ovr_second_valid", valid_o, 1);
                check("ovr_pulse", overrun_o, 1);
                wait_neg(p + 160 + 156);
                check("ovr_pulse_end", overrun_o, 0);
            end
        join
        p = cyc;
        ready_man = 1'b1;
        tick();
        ready_man = 1'b0;
        @(negedge clk);
        check("ovr_accept_drop", valid_o, 0);
        repeat (5) tick();

        // Simultaneous accept and load: ready high only in the load cycle
        p = cyc;
        exp_q.push_back(8'h66);
        exp_q.push_back(8'h77);
        fork
            begin
                send_frame(8'h66, 1'b1);
                send_frame(8'h77, 1'b1);
            end
            begin
                at_cycle(p + 160 + 154);
                ready_man = 1'b1;
                tick();
                ready_man = 1'b0;
                wait_neg(p + 160 + 155);
                check("sim_valid", valid_o, 1);
                check("sim_data", data_o, 8'h77);
                check("sim_no_ovr", overrun_o, 0);
            end
        join
        ready_man = 1'b1;
        tick();
        ready_man = 1'b0;
        repeat (5) tick();

        // Reset mid-frame with a byte pending
        exp_q.push_back(8'h42);
        send_frame(8'h42, 1'b1);
        p = cyc;
        fork
            send_frame(8'hFF, 1'b1);
            begin
                at_cycle(p + 88);
                rst = 1'b1;
                exp_q.delete();
                tick();
                rst = 1'b0;
                wait_neg(p + 89);
                check("mid_rst_valid", valid_o, 0);
                check("mid_rst_data", data_o, 0);
                check("mid_rst_busy", busy_o, 0);
                check("mid_rst_ferr", frame_err_o, 0);
                check("mid_rst_ovr", overrun_o, 0);
            end
        join
        repeat (5) tick();
        check("post_rst_no_valid", valid_o, 0);
        ready_man = 1'b1;
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        repeat (20) tick();

        // Randomised frames with a random consumer
        rnd_mode = 1'b1;
        for (int n = 0; n < 16; n++) begin
            b    = 8'($urandom_range(0, 255));
            good = ($urandom_range(0, 5) != 0);
            if (good) begin
                exp_q.push_back(b);
                send_frame(b, 1'b1);
                repeat ($urandom_range(0, 12)) tick();
            end else begin
                exp_ferr++;
                send_frame(b, 1'b0);
                repeat ($urandom_range(0, 30)) tick();
                rx_i = 1'b1;
                repeat ($urandom_range(1, 12)) tick();
            end
        end
        repeat (200) tick();
        rnd_mode  = 1'b0;
        ready_man = 1'b1;
        repeat (10) tick();

        // Final scoreboard state
        check("queue_drained", exp_q.size(), 0);
        check("frame_err_count", n_ferr, exp_ferr);
        check("overrun_count", n_ovr, exp_ovr);
        check("final_valid", valid_o, 0);
        check("final_busy", busy_o, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
